imm_extend_pipe: RTL and testbench
==================================

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 16: immediate input width.
REQ-002 SHALL have parameter OUT_W, default 32: extended output width; legal only when OUT_W >= IN_W+2.
REQ-003 SHALL have parameter CNT_W, default 16: width of the transfer counter.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1: input beat offered.
REQ-007 SHALL have port in_ready, output, 1: block can accept a beat.
REQ-008 SHALL have port in_imm, input, IN_W: raw immediate field.
REQ-009 SHALL have port in_mode, input, 2: extension mode, where 00 is SIGN, 01 is ZERO, 10 is UPPER and 11 is BRANCH.
REQ-010 SHALL have port out_valid, output, 1: result beat valid.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts the beat.
REQ-012 SHALL have port out_imm, output, OUT_W: extended result.
REQ-013 SHALL have port out_neg, output, 1: MSB of out_imm.
REQ-014 SHALL have port xfer_cnt, output, CNT_W: count of completed output transfers.

Function
REQ-015 SHALL compute SIGN as in_imm replicated-MSB extended to OUT_W.
REQ-016 SHALL compute ZERO as in_imm zero-extended to OUT_W.
REQ-017 SHALL compute UPPER as in_imm placed in the top IN_W bits, with the low OUT_W-IN_W bits cleared.
REQ-018 SHALL compute BRANCH as the SIGN result shifted left by 2, low 2 bits zero, upper bits discarded.
REQ-019 SHALL sample mode and immediate only on an input transfer (in_valid && in_ready); both are ignored otherwise.
REQ-020 SHALL present each accepted beat on out_imm with out_valid high exactly 1 cycle after acceptance when the output stage is empty or draining.
REQ-021 SHALL complete an output transfer when out_valid && out_ready.
REQ-022 SHALL hold out_imm, out_neg and out_valid stable while out_valid && !out_ready.
REQ-023 SHALL buffer with a 2-entry skid structure (output register plus skid register).
REQ-024 SHALL drive in_ready from a register as !skid_full, never combinationally from out_ready.
REQ-025 SHALL route a beat accepted while the output is stalled into the skid register, and then set skid_full.
REQ-026 SHALL move the skid register into the output register when the output completes and skid_full is set, clear skid_full, and raise in_ready on the next cycle.
REQ-027 SHALL, on simultaneous input accept and output completion with skid empty, load the output register with the new beat, keeping out_valid high with no bubble.
REQ-028 SHALL preserve beat order with no loss and no duplication under any valid/ready pattern.
REQ-029 SHALL increment xfer_cnt by 1 per output transfer, wrapping from all-ones to 0.

Reset
REQ-030 SHALL, while rst_n is low, immediately force out_valid=0, out_imm=0, out_neg=0, xfer_cnt=0, skid_full=0 and in_ready=0.
REQ-031 SHALL set in_ready to 1 on the first clk edge after rst_n deasserts.
REQ-032 SHALL discard any in-flight or skid beat on reset asserted mid-operation, with no output transfer counted.

Structure
REQ-033 SHALL take the mode encodings (SIGN, ZERO, UPPER, BRANCH) and the default widths from the shared package imm_pkg.
REQ-034 SHALL keep the extension function combinational on the input side of the buffer.
REQ-035 SHALL implement the skid buffer as one sub-module, skid_buf, parametrised by data width OUT_W.

Verification
REQ-036 SHALL cover mode SIGN: in_imm=0x8001 with out_ready=1 -> out_imm=0xFFFF8001, out_neg=1, one cycle later.
REQ-037 SHALL cover modes ZERO and UPPER: 0x8001/ZERO -> 0x00008001, out_neg=0; 0x1234/UPPER -> 0x12340000.
REQ-038 SHALL cover mode BRANCH: 0xFFFF -> 0xFFFFFFFC; 0x7FFF -> 0x0001FFFC.
REQ-039 SHALL cover backpressure: out_ready=0 with beats 0x0001, 0x0002, 0x0003 offered back-to-back (SIGN) -> in_ready low after 2 accepts; on out_ready=1 the outputs are 0x00000001, 0x00000002, 0x00000003 in order and xfer_cnt=3.
REQ-040 SHALL cover streaming: continuous in_valid and out_ready for 100 beats -> 1 result per cycle, no bubble, xfer_cnt=100.
REQ-041 SHALL cover reset mid-stall: skid full, then rst_n pulsed low -> out_valid=0 and xfer_cnt=0 immediately, in_ready=1 one edge after release, and no stale beat emitted.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-extension pipeline: mode encodings
// and default widths.
package imm_pkg;

  localparam int unsigned IMM_IN_W  = 16;
  localparam int unsigned IMM_OUT_W = 32;
  localparam int unsigned IMM_CNT_W = 16;

  typedef enum logic [1:0] {
    MODE_SIGN   = 2'b00,
    MODE_ZERO   = 2'b01,
    MODE_UPPER  = 2'b10,
    MODE_BRANCH = 2'b11
  } imm_mode_e;

endpackage

// File: rtl/imm_extend_pipe_skid_buf.sv
// Two-entry skid buffer: output register plus one skid register, with a
// registered ready so upstream never sees a combinational path from out_ready.
module skid_buf #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         skid_full;
  logic [W-1:0] skid_data;
  logic         accept;
  logic         out_free;

  assign accept   = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;

  // in_ready always mirrors !skid_full; branches below override it on the
  // cycles where skid_full itself changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_full <= 1'b0;
      skid_data <= '0;
      in_ready  <= 1'b0;
    end else begin
      in_ready <= !skid_full;
      if (out_free) begin
        if (skid_full) begin
          out_data  <= skid_data;
          out_valid <= 1'b1;
          skid_full <= 1'b0;
          in_ready  <= 1'b1;
        end else if (accept) begin
          out_data  <= in_data;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (accept) begin
        skid_data <= in_data;
        skid_full <= 1'b1;
        in_ready  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate extension (sign/zero/upper/branch) followed by a skid buffer
// and a wrapping count of completed output transfers.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int unsigned IN_W  = IMM_IN_W,
  parameter int unsigned OUT_W = IMM_OUT_W,
  parameter int unsigned CNT_W = IMM_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic             out_neg,
  output logic [CNT_W-1:0] xfer_cnt
);

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] upper;
  logic [OUT_W-1:0] branch;
  logic [OUT_W-1:0] ext;

  assign sext   = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
  assign zext   = {{(OUT_W-IN_W){1'b0}}, in_imm};
  assign upper  = {in_imm, {(OUT_W-IN_W){1'b0}}};
  assign branch = {sext[OUT_W-3:0], 2'b00};

  always_comb begin
    ext = sext;
    unique case (imm_mode_e'(in_mode))
      MODE_SIGN:   ext = sext;
      MODE_ZERO:   ext = zext;
      MODE_UPPER:  ext = upper;
      MODE_BRANCH: ext = branch;
      default:     ext = sext;
    endcase
  end

  skid_buf #(
    .W (OUT_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (ext),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_imm)
  );

  assign out_neg = out_imm[OUT_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt <= '0;
    end else if (out_valid && out_ready) begin
      xfer_cnt <= xfer_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: per-mode vectors, backpressure,
// full-rate streaming and reset while the skid register is occupied.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_imm = '0;
  logic [1:0]  in_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_imm;
  logic        out_neg;
  logic [15:0] xfer_cnt;

  int unsigned total = 0;
  int unsigned bad = 0;
  logic [31:0] got_q[$];

  imm_extend_pipe #(
    .IN_W  (16),
    .OUT_W (32),
    .CNT_W (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm),
    .out_neg   (out_neg),
    .xfer_cnt  (xfer_cnt)
  );

  always #5 clk = ~clk;

  // Transfers complete on the next rising edge; record them mid-cycle.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) got_q.push_back(out_imm);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One beat with out_ready=1: result visible one edge after acceptance.
  task automatic one_beat(input string tag, input logic [15:0] imm, input logic [1:0] mode,
                          input logic [31:0] exp, input logic [15:0] exp_cnt);
    in_imm   = imm;
    in_mode  = mode;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_imm   = 16'h5A5A;
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_imm"}, out_imm, exp);
    check({tag, "_neg"}, out_neg, exp[31]);
    tick();
    check({tag, "_drained"}, out_valid, 1'b0);
    check({tag, "_cnt"}, xfer_cnt, exp_cnt);
  endtask

  initial begin
    int unsigned stream_err;

    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_imm", out_imm, 32'h0);
    check("rst_out_neg", out_neg, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_xfer_cnt", xfer_cnt, 16'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rel_in_ready", in_ready, 1'b1);

    out_ready = 1'b1;
    one_beat("sign_8001",   16'h8001, 2'b00, 32'hFFFF8001, 16'd1);
    one_beat("zero_8001",   16'h8001, 2'b01, 32'h00008001, 16'd2);
    one_beat("upper_1234",  16'h1234, 2'b10, 32'h12340000, 16'd3);
    one_beat("branch_ffff", 16'hFFFF, 2'b11, 32'hFFFFFFFC, 16'd4);
    one_beat("branch_7fff", 16'h7FFF, 2'b11, 32'h0001FFFC, 16'd5);

    // Inputs are ignored without in_valid.
    in_imm  = 16'hDEAD;
    in_mode = 2'b10;
    tick();
    check("idle_no_valid", out_valid, 1'b0);
    check("idle_cnt", xfer_cnt, 16'd5);

    // Backpressure: two accepts fill output and skid, third beat waits.
    got_q.delete();
    out_ready = 1'b0;
    in_mode   = 2'b00;
    in_valid  = 1'b1;
    in_imm    = 16'h0001;
    tick();
    in_imm = 16'h0002;
    tick();
    check("bp_in_ready_low", in_ready, 1'b0);
    in_imm = 16'h0003;
    tick();
    check("bp_hold_valid", out_valid, 1'b1);
    check("bp_hold_imm", out_imm, 32'h00000001);
    check("bp_in_ready_still_low", in_ready, 1'b0);
    out_ready = 1'b1;
    tick();
    check("bp_skid_to_out", out_imm, 32'h00000002);
    check("bp_ready_back", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check("bp_third", out_imm, 32'h00000003);
    tick();
    tick();
    check("bp_count_q", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check("bp_order0", got_q[0], 32'h00000001);
      check("bp_order1", got_q[1], 32'h00000002);
      check("bp_order2", got_q[2], 32'h00000003);
    end
    check("bp_xfer_cnt", xfer_cnt, 16'd8);

    // Reset with the skid register occupied discards both beats.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_imm    = 16'hAAAA;
    tick();
    in_imm = 16'hBBBB;
    tick();
    in_valid = 1'b0;
    check("mr_skid_full", in_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mr_out_valid", out_valid, 1'b0);
    check("mr_xfer_cnt", xfer_cnt, 16'h0);
    check("mr_in_ready", in_ready, 1'b0);
    got_q.delete();
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    check("mr_rel_in_ready", in_ready, 1'b1);
    tick();
    tick();
    check("mr_no_stale_valid", out_valid, 1'b0);
    check("mr_no_stale_q", got_q.size(), 0);
    check("mr_cnt_zero", xfer_cnt, 16'h0);

    // Streaming: one result per cycle with no bubble.
    stream_err = 0;
    in_mode  = 2'b01;
    in_valid = 1'b1;
    for (int unsigned i = 0; i < 100; i++) begin
      in_imm = 16'(i + 16'h0100);
      tick();
      if (!(in_ready && out_valid && out_imm == 32'(i + 16'h0100))) stream_err++;
    end
    in_valid = 1'b0;
    tick();
    tick();
    check("stream_bubbles", stream_err, 0);
    check("stream_q_size", got_q.size(), 100);
    check("stream_xfer_cnt", xfer_cnt, 16'd100);
    if (got_q.size() == 100) begin
      check("stream_first", got_q[0], 32'h00000100);
      check("stream_last", got_q[99], 32'h00000163);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
